// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: column-multiplexed LED matrix driver with a double-buffered, tear-free frame load.
// Define LED_SCAN_BLANK_EN to insert BLANK_CYCLES of blanking after every column dwell.
module led_matrix_scanner #(
   parameter int ROWS         = 8,
   parameter int COLS         = 8,
   parameter int DWELL_CYCLES = 1000,
   parameter int BLANK_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ena,
   input  logic [ROWS*COLS-1:0] cells,
   input  logic                 load,
   output logic                 load_ready,
   output logic [ROWS-1:0]      rows,
   output logic [COLS-1:0]      cols,
   output logic                 frame_done
);
   localparam int CW = $clog2(COLS);
   localparam int DW = $clog2(DWELL_CYCLES + 1);
   localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

   if (ROWS < 1 || ROWS > 16) begin : g_rows_chk
      $error("led_matrix_scanner: ROWS=%0d outside 1..16", ROWS);
   end
   if (COLS < 2 || COLS > 16) begin : g_cols_chk
      $error("led_matrix_scanner: COLS=%0d outside 2..16", COLS);
   end
   if (DWELL_CYCLES < 1) begin : g_dwell_chk
      $error("led_matrix_scanner: DWELL_CYCLES must be >= 1");
   end
   if (BLANK_CYCLES < 1) begin : g_blank_chk
      $error("led_matrix_scanner: BLANK_CYCLES must be >= 1");
   end

`ifdef LED_SCAN_BLANK_EN
   localparam int BW = $clog2(BLANK_CYCLES + 1);
   localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, SCAN, BLANK} state_t;
   logic [BW-1:0] blank_q, blank_d;
`else
   typedef enum logic {IDLE, SCAN} state_t;
`endif

   state_t               state_q, state_d;
   logic [CW-1:0]        col_q, col_d;
   logic [DW-1:0]        dwell_q, dwell_d;
   logic [ROWS*COLS-1:0] display_q, display_d;
   logic [ROWS*COLS-1:0] pending_q, pending_d;
   logic                 ready_q, ready_d;
   logic [ROWS-1:0]      rows_q, rows_d;
   logic [COLS-1:0]      cols_q, cols_d;
   logic                 frame_q;
   logic                 wrap;
   logic                 last_col;
   logic [CW-1:0]        col_inc;

   assign last_col = col_q == COL_LAST;
   assign col_inc  = last_col ? '0 : col_q + CW'(1);

   // ready_q low means the pending buffer holds a frame waiting for the next boundary
   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      dwell_d   = dwell_q;
`ifdef LED_SCAN_BLANK_EN
      blank_d   = blank_q;
`endif
      display_d = display_q;
      pending_d = pending_q;
      ready_d   = ready_q;
      wrap      = 1'b0;
      rows_d    = '1;
      if (load && ready_q) begin
         pending_d = cells;
         ready_d   = 1'b0;
      end
      case (state_q)
         IDLE: begin
            if (!ready_q) begin
               display_d = pending_q;
               ready_d   = 1'b1;
            end
            state_d = ena ? SCAN : IDLE;
         end
         SCAN: begin
            if (!ena) begin
               state_d = IDLE;
               col_d   = '0;
               dwell_d = '0;
            end else if (dwell_q == DWELL_LAST) begin
               dwell_d = '0;
`ifdef LED_SCAN_BLANK_EN
               state_d = BLANK;
`else
               col_d   = col_inc;
               wrap    = last_col;
`endif
            end else begin
               dwell_d = dwell_q + DW'(1);
            end
         end
`ifdef LED_SCAN_BLANK_EN
         BLANK: begin
            if (!ena) begin
               state_d = IDLE;
               col_d   = '0;
               blank_d = '0;
            end else if (blank_q == BLANK_LAST) begin
               state_d = SCAN;
               blank_d = '0;
               col_d   = col_inc;
               wrap    = last_col;
            end else begin
               blank_d = blank_q + BW'(1);
            end
         end
`endif
         default: state_d = IDLE;
      endcase
      // swapping only on the wrap keeps every frame whole on the matrix
      if (wrap && !ready_q) begin
         display_d = pending_q;
         ready_d   = 1'b1;
      end
      cols_d = (state_d == SCAN) ? COLS'(1) << col_d : '0;
      for (int r = 0; r < ROWS; r++) rows_d[r] = ~|(display_d[r*COLS +: COLS] & cols_d);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         col_q     <= '0;
         dwell_q   <= '0;
         display_q <= '0;
         pending_q <= '0;
         ready_q   <= 1'b1;
         rows_q    <= '1;
         cols_q    <= '0;
         frame_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         dwell_q   <= dwell_d;
         display_q <= display_d;
         pending_q <= pending_d;
         ready_q   <= ready_d;
         rows_q    <= rows_d;
         cols_q    <= cols_d;
         frame_q   <= wrap;
      end
   end

`ifdef LED_SCAN_BLANK_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) blank_q <= '0;
      else blank_q <= blank_d;
   end
`endif

   assign load_ready = ready_q;
   assign rows       = rows_q;
   assign cols       = cols_q;
   assign frame_done = frame_q;
endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner: randomized scoreboard bench for led_matrix_scanner.
// A time-based reference model predicts each cycle's outputs; a monitor pops and compares them.
module tb_led_matrix_scanner;
   localparam int ROWS  = 8;
   localparam int COLS  = 8;
   localparam int DWELL = 4;
   localparam int BLANK = 2;
`ifdef LED_SCAN_BLANK_EN
   localparam int PERIOD = DWELL + BLANK;
`else
   localparam int PERIOD = DWELL;
`endif
   localparam int FRAME = COLS * PERIOD;

   typedef struct packed {
      logic [ROWS-1:0] rows;
      logic [COLS-1:0] cols;
      logic            fd;
      logic            ready;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 ena = 1'b0;
   logic                 load = 1'b0;
   logic [ROWS*COLS-1:0] cells = '0;
   logic                 load_ready;
   logic                 frame_done;
   logic [ROWS-1:0]      rows;
   logic [COLS-1:0]      cols;
   int                   checks = 0;
   int                   errors = 0;
   exp_t                 q[$];

   led_matrix_scanner #(
      .ROWS(ROWS), .COLS(COLS), .DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)
   ) dut (
      .clk(clk), .rst(rst), .ena(ena), .cells(cells), .load(load),
      .load_ready(load_ready), .rows(rows), .cols(cols), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // model: scan position is just elapsed cycles modulo the frame length
   bit          m_run = 1'b0;
   bit          m_full = 1'b0;
   int          m_t = 0;
   logic [63:0] m_disp = '0;
   logic [63:0] m_pend = '0;

   initial forever begin : model
      bit   accept;
      bit   fd;
      int   c;
      exp_t e;
      @(posedge clk or negedge rst);
      if (!rst) begin
         m_run = 0; m_full = 0; m_t = 0; m_disp = '0; m_pend = '0;
         q.delete();
      end else begin
         accept = load && !m_full;
         fd = 0;
         if (!m_run) begin
            if (m_full) begin m_disp = m_pend; m_full = 0; end
            m_run = ena;
            m_t = 0;
         end else if (!ena) begin
            m_run = 0;
            m_t = 0;
         end else begin
            m_t = (m_t + 1) % FRAME;
            if (m_t == 0) begin
               fd = 1;
               if (m_full) begin m_disp = m_pend; m_full = 0; end
            end
         end
         if (accept) begin m_pend = cells; m_full = 1; end
         c = m_t / PERIOD;
         e.cols = (m_run && (m_t % PERIOD) < DWELL) ? COLS'(1) << c : '0;
         for (int r = 0; r < ROWS; r++) e.rows[r] = (e.cols != 0) ? ~m_disp[COLS*r + c] : 1'b1;
         e.fd = fd;
         e.ready = !m_full;
         q.push_back(e);
      end
   end

   initial forever begin : monitor
      exp_t e;
      @(negedge clk);
      if (rst && q.size() > 0) begin
         e = q.pop_front();
         check("rows", 64'(rows), 64'(e.rows));
         check("cols", 64'(cols), 64'(e.cols));
         check("frame_done", 64'(frame_done), 64'(e.fd));
         check("load_ready", 64'(load_ready), 64'(e.ready));
      end
   end

   task automatic wait_cols(input logic [COLS-1:0] pat, input bit want_fd, input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(want_fd ? frame_done : (cols == pat)) && n < 500);
      check(name, 64'(n < 500), 64'(1));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 64'(load_ready), 64'(1));
      check({tag, "_rows"}, 64'(rows), 64'(8'hFF));
      check({tag, "_cols"}, 64'(cols), 64'(0));
      check({tag, "_fd"}, 64'(frame_done), 64'(0));
   endtask

   initial begin
      #2 rst = 1'b0;
      #1 check_reset_outputs("reset");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      // basic scan: single lit cell at row 0, column 0, swapped in while idle
      @(negedge clk); load = 1'b1; cells = 64'h1;
      @(negedge clk); load = 1'b0;
      @(negedge clk); ena = 1'b1;
      repeat (2 * FRAME) @(negedge clk);
      // tear-free swap at cycle 10, then an ignored back-to-back all-zero load
      wait_cols('0, 1'b1, "wait_frame");
      repeat (9) @(negedge clk);
      load = 1'b1; cells = '1;
      @(negedge clk); cells = '0;
      @(negedge clk); load = 1'b0;
      repeat (2 * FRAME) @(negedge clk);
      // drop enable in column 5, then restart
      wait_cols(8'h20, 1'b0, "wait_col5");
      ena = 1'b0;
      repeat (3) @(negedge clk);
      ena = 1'b1;
      repeat (FRAME + 5) @(negedge clk);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         ena = $urandom_range(0, 99) < 97;
         load = $urandom_range(0, 3) == 0;
         cells = {$urandom(), $urandom()};
      end
      // asynchronous reset mid-scan discards all frame data
      ena = 1'b1; load = 1'b1; cells = '1;
      @(negedge clk); load = 1'b0;
      repeat (FRAME + FRAME / 2) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      #1 check_reset_outputs("async_reset");
      @(negedge clk); rst = 1'b1;
      repeat (FRAME + 5) @(negedge clk);
      check("scoreboard_activity", 64'(checks > 10000), 64'(1));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/led_matrix_scanner.md
LED_MATRIX_SCANNER -- requirements
Module: led_matrix_scanner

Interface
REQ-001 Parameter ROWS, default 8: number of LED rows, SHALL be legal for 1..16; an $error SHALL fire outside this range.
REQ-002 Parameter COLS, default 8: number of LED columns, SHALL be legal for 2..16; an $error SHALL fire outside this range.
REQ-003 Parameter DWELL_CYCLES, default 1000: clock cycles each column is driven, SHALL be >= 1.
REQ-004 Parameter BLANK_CYCLES, default 2: inter-column blanking length, used only under LED_SCAN_BLANK_EN, SHALL be >= 1.
REQ-005 Port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port ena, input, 1 bit: scan enable.
REQ-008 Port cells, input, ROWS*COLS bits: new frame data, where cells[COLS*r+c] lights row r, column c.
REQ-009 Port load, input, 1 bit: frame-load request.
REQ-010 Port load_ready, output, 1 bit: high when the pending buffer is empty.
REQ-011 Port rows, output, ROWS bits: row drives, active-low.
REQ-012 Port cols, output, COLS bits: column select, one-hot, active-high.
REQ-013 Port frame_done, output, 1 bit: one-cycle pulse at the end of each frame.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 States SHALL be: IDLE, SCAN, and BLANK (BLANK only under the macro).
REQ-016 In IDLE, cols SHALL be all-0 and rows SHALL be all-1.
REQ-017 IDLE SHALL go to SCAN with column 0 on the first edge with ena=1.
REQ-018 In SCAN, cols SHALL be one-hot at the column index, and rows[r] SHALL equal ~display[COLS*r+col].
REQ-019 Each column SHALL stay in SCAN for exactly DWELL_CYCLES cycles, timed by a dwell counter of width $clog2(DWELL_CYCLES+1).
REQ-020 At the end of a dwell, the column index SHALL increment; COLS-1 SHALL wrap to 0.
REQ-021 On the wrap from COLS-1 to 0, frame_done SHALL pulse for one cycle aligned with the first cycle of column 0.
REQ-022 Handshake: the pending buffer SHALL capture cells on any edge with load=1 and load_ready=1; load_ready SHALL fall on the next cycle.
REQ-023 A load with load_ready=0 SHALL be ignored and SHALL NOT corrupt the pending buffer.
REQ-024 At a frame boundary (the wrap edge) with the pending buffer full, pending SHALL be copied to display, and load_ready SHALL rise on the next cycle. There SHALL be no mid-frame tearing.
REQ-025 A load accepted on the same edge as a frame boundary SHALL take effect at the following boundary, not the current one.
REQ-026 In IDLE, a full pending buffer SHALL be copied to display immediately, with load_ready rising on the next cycle.
REQ-027 If ena falls mid-frame, the state SHALL go to IDLE on the next edge. The column index and dwell counter SHALL clear. frame_done SHALL NOT pulse. The next ena starts at column 0.
REQ-028 Buffer width SHALL be exactly ROWS*COLS bits.

Reset
REQ-029 When rst=0, the block SHALL immediately force state=IDLE, col=0, dwell=0, display=0, and pending empty.
REQ-030 During reset, outputs SHALL be load_ready=1, rows=all-1, cols=0, and frame_done=0.
REQ-031 A reset asserted mid-frame or mid-load SHALL discard all frame data.

Configuration
REQ-032 Macro LED_SCAN_BLANK_EN, when defined, SHALL insert BLANK for BLANK_CYCLES cycles after every column dwell, including the wrap.
REQ-033 In BLANK, cols SHALL be 0 and rows SHALL be all-1.
REQ-034 Under the macro, frame_done and the buffer swap SHALL occur on the BLANK-to-column-0 edge.
REQ-035 Without the macro, SCAN SHALL advance column-to-column with no gap, and the BLANK state and its counter SHALL NOT exist.

Verification
REQ-036 Basic scan: ROWS=COLS=8, DWELL=4, load cells=64'h0000_0000_0000_0001, ena=1. After the swap, cols=8'h01 and rows=8'hFE for 4 cycles, then cols=8'h02 and rows=8'hFF.
REQ-037 Frame timing: with DWELL=4 and no macro, frame_done SHALL pulse every 32 cycles. With the macro and BLANK=2, it SHALL pulse every 48 cycles.
REQ-038 Tear-free swap: load all-1 at cycle 10 of a frame. The display SHALL stay at the old frame until the wrap, and load_ready SHALL be 0 from cycle 11 until one cycle after the wrap.
REQ-039 Back-to-back load with load_ready=0 and cells=all-0 SHALL be ignored; the first-loaded frame SHALL be displayed.
REQ-040 Drop ena in column 5: on the next edge, cols=0 and rows=8'hFF. On re-enable, the scan restarts at cols=8'h01 with no frame_done.
REQ-041 Assert rst=0 mid-scan: outputs SHALL be at reset values without a clock edge, and load_ready=1.
